// File: rtl/match_frame_sched_if.sv
// Signal bundle between the upstream feature stage, the frame scheduler and the matcher.
// The slave modport is the scheduler's view of the bundle.
interface match_frame_sched_if;
    logic         i_start;
    logic         i_end;
    logic         i_flag;
    logic [9:0]   i_coordinate_X;
    logic [9:0]   i_coordinate_Y;
    logic [7:0]   i_score;
    logic [255:0] i_descriptor;
    logic         o_ready;
    logic         o_mt_start;
    logic         o_mt_end;
    logic         o_mt_flag;
    logic [9:0]   o_mt_coor_x;
    logic [9:0]   o_mt_coor_y;
    logic [7:0]   o_mt_score;
    logic [255:0] o_mt_descriptor;
    logic         i_mt_valid;
    logic         i_mt_end;
    logic         o_busy;
    logic         o_frame_done;
    logic         o_timeout;
    logic [7:0]   o_frame_id;
    logic [9:0]   o_key_cnt;
    logic [9:0]   o_drop_cnt;
    logic [9:0]   o_match_cnt;

    modport slave (
        input  i_start, i_end, i_flag, i_coordinate_X, i_coordinate_Y, i_score, i_descriptor,
        input  i_mt_valid, i_mt_end,
        output o_ready, o_mt_start, o_mt_end, o_mt_flag, o_mt_coor_x, o_mt_coor_y,
        output o_mt_score, o_mt_descriptor, o_busy, o_frame_done, o_timeout,
        output o_frame_id, o_key_cnt, o_drop_cnt, o_match_cnt
    );

    modport master (
        output i_start, i_end, i_flag, i_coordinate_X, i_coordinate_Y, i_score, i_descriptor,
        output i_mt_valid, i_mt_end,
        input  o_ready, o_mt_start, o_mt_end, o_mt_flag, o_mt_coor_x, o_mt_coor_y,
        input  o_mt_score, o_mt_descriptor, o_busy, o_frame_done, o_timeout,
        input  o_frame_id, o_key_cnt, o_drop_cnt, o_match_cnt
    );
endinterface

// File: rtl/match_frame_sched.sv
// Frame scheduler: admits one frame at a time, caps keypoints, forwards them to the
// matcher with one registered cycle, then waits for matcher end (or timeout).
module match_frame_sched #(
    parameter int MAX_KEYS = 500,
    parameter int TIMEOUT  = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    match_frame_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

    state_t       state, state_nxt;
    logic [15:0]  tcnt;
    logic [9:0]   key_cnt, drop_cnt, match_cnt, keys_base;
    logic [7:0]   frame_id;
    logic         timeout_flag, frame_done, mt_start, mt_end, mt_flag;
    logic [9:0]   mt_x, mt_y;
    logic [7:0]   mt_score;
    logic [255:0] mt_desc;
    logic         take_start, take_end, key_seen, take_key, drop_key, limit;

    always_comb begin
        take_start = (state == IDLE) && bus.i_start;
        // A start cycle counts its keypoint against a freshly cleared frame.
        keys_base  = take_start ? 10'd0 : key_cnt;
        take_end   = (take_start || state == RECV) && bus.i_end;
        key_seen   = (take_start || state == RECV) && bus.i_flag;
        take_key   = key_seen && ({1'b0, keys_base} < 11'(MAX_KEYS));
        drop_key   = key_seen && !take_key;
        limit      = (tcnt == 16'(TIMEOUT - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (take_start) state_nxt = take_end ? DRAIN : RECV;
            RECV:  if (take_end) state_nxt = DRAIN;
            DRAIN: if (bus.i_mt_end || limit) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tcnt         <= '0;
            key_cnt      <= '0;
            drop_cnt     <= '0;
            match_cnt    <= '0;
            frame_id     <= '0;
            timeout_flag <= 1'b0;
            frame_done   <= 1'b0;
            mt_start     <= 1'b0;
            mt_end       <= 1'b0;
            mt_flag      <= 1'b0;
            mt_x         <= '0;
            mt_y         <= '0;
            mt_score     <= '0;
            mt_desc      <= '0;
        end else begin
            tcnt       <= (state == DRAIN) ? tcnt + 16'd1 : 16'd0;
            mt_start   <= take_start;
            mt_end     <= take_end;
            mt_flag    <= take_key;
            frame_done <= (state == DRAIN) && (state_nxt == DONE);
            if (take_key) begin
                mt_x     <= bus.i_coordinate_X;
                mt_y     <= bus.i_coordinate_Y;
                mt_score <= bus.i_score;
                mt_desc  <= bus.i_descriptor;
            end
            if (take_start) begin
                frame_id     <= frame_id + 8'd1;
                timeout_flag <= 1'b0;
                key_cnt      <= 10'(take_key);
                drop_cnt     <= 10'(drop_key);
                match_cnt    <= '0;
            end else begin
                if (take_key) key_cnt <= keys_base + 10'd1;
                if (drop_key && drop_cnt != 10'h3ff) drop_cnt <= drop_cnt + 10'd1;
                if (state != IDLE && bus.i_mt_valid && match_cnt != 10'h3ff)
                    match_cnt <= match_cnt + 10'd1;
                // A matcher end on the limit cycle still counts as normal completion.
                if (state == DRAIN && limit && !bus.i_mt_end) timeout_flag <= 1'b1;
            end
        end
    end

    assign bus.o_ready         = (state == IDLE) || (state == RECV);
    assign bus.o_busy          = (state != IDLE);
    assign bus.o_mt_start      = mt_start;
    assign bus.o_mt_end        = mt_end;
    assign bus.o_mt_flag       = mt_flag;
    assign bus.o_mt_coor_x     = mt_x;
    assign bus.o_mt_coor_y     = mt_y;
    assign bus.o_mt_score      = mt_score;
    assign bus.o_mt_descriptor = mt_desc;
    assign bus.o_frame_done    = frame_done;
    assign bus.o_timeout       = timeout_flag;
    assign bus.o_frame_id      = frame_id;
    assign bus.o_key_cnt       = key_cnt;
    assign bus.o_drop_cnt      = drop_cnt;
    assign bus.o_match_cnt     = match_cnt;
endmodule

// File: doc/match_frame_sched.md
# match_frame_sched

Frame scheduler in front of the keypoint matcher. Admits one frame of keypoints at a time from the feature-extraction stream, caps the per-frame keypoint count, and forwards accepted keypoints to the matcher with one cycle of registered latency. It holds off upstream until the matcher signals end of matching for that frame, guarded by a timeout, and publishes per-frame statistics. It sits between the FAST/BRIEF output stage and the matcher top level.

## Interface
- MAX_KEYS, 500: maximum keypoints forwarded per frame; must be ≤ 1023.
- TIMEOUT, 4096: DRAIN-state cycle limit; must be 1 to 65535.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  frame-start strobe from upstream.
- i_end  in  1  frame-end strobe from upstream.
- i_flag  in  1  keypoint valid.
- i_coordinate_X  in  10  keypoint X.
- i_coordinate_Y  in  10  keypoint Y.
- i_score  in  8  keypoint score.
- i_descriptor  in  256  BRIEF descriptor.
- o_ready  out  1  upstream may present start, keypoints or end.
- o_mt_start  out  1  one-cycle frame-start pulse to matcher.
- o_mt_end  out  1  one-cycle frame-end pulse to matcher.
- o_mt_flag  out  1  forwarded keypoint valid.
- o_mt_coor_x  out  10  forwarded X.
- o_mt_coor_y  out  10  forwarded Y.
- o_mt_score  out  8  forwarded score.
- o_mt_descriptor  out  256  forwarded descriptor.
- i_mt_valid  in  1  matcher emitted a match pair.
- i_mt_end  in  1  matcher finished the frame.
- o_busy  out  1  state ≠ IDLE.
- o_frame_done  out  1  one-cycle pulse in DONE.
- o_timeout  out  1  last frame ended by timeout; sticky.
- o_frame_id  out  8  accepted-frame counter; wraps 255→0.
- o_key_cnt  out  10  keypoints forwarded in the current or last frame.
- o_drop_cnt  out  10  in-frame keypoints dropped by the cap; saturates at 1023.
- o_match_cnt  out  10  i_mt_valid pulses counted in the frame; saturates at 1023.

## Operation
- States: IDLE, RECV, DRAIN, DONE. o_ready = 1 in IDLE and RECV, 0 in DRAIN and DONE. Upstream must not assert strobes while o_ready = 0; any strobes presented then are ignored.
- IDLE:
  - i_start → RECV. In the same edge: clear key, drop and match counters; clear o_timeout; increment o_frame_id. Register o_mt_start = 1 for one cycle.
  - i_flag or i_end without i_start → ignored, not counted.
- RECV:
  - i_flag with o_key_cnt < MAX_KEYS → forward the keypoint and increment o_key_cnt.
  - i_flag with o_key_cnt = MAX_KEYS → drop the keypoint and increment o_drop_cnt (saturating).
  - i_end → DRAIN. Register o_mt_end = 1 for one cycle.
  - i_start while in RECV → ignored.
- Simultaneous strobes, start cycle:
  - i_start + i_flag → the keypoint is the first of the new frame.
  - i_start + i_end → zero-keypoint frame; go straight to DRAIN. o_mt_start and o_mt_end are both asserted in the following cycle.
- Simultaneous strobes, end cycle: i_flag + i_end → the keypoint is accepted, subject to the cap, before the end.
- DRAIN:
  - The timeout counter counts from 0 on DRAIN entry.
  - i_mt_end → DONE with o_timeout = 0.
  - Counter reaches TIMEOUT−1 without i_mt_end → DONE with o_timeout = 1.
  - i_mt_end arriving on the limit cycle → normal completion (o_timeout = 0).
- DONE: o_frame_done = 1 for exactly one cycle, then → IDLE. Statistics stay stable until the next accepted i_start.
- Match counting: i_mt_valid is counted in RECV, DRAIN and DONE. It is ignored in IDLE.
- Counter widths:
  - o_key_cnt: 10 bits; never exceeds MAX_KEYS.
  - o_drop_cnt and o_match_cnt: saturate at 1023.
  - Timeout counter: 16 bits.

## Timing
- Forward path: keypoint accepted at edge N → o_mt_flag and data valid from edge N+1 for one cycle. o_mt_flag = 0 otherwise.
- Data outputs hold their last value when o_mt_flag = 0.
- o_mt_start and o_mt_end are registered pulses, one cycle after the accepting edge.
- o_ready, o_busy: combinational from state.
- Other status outputs: registered.
- Reset values (also on mid-frame reset):
  - state = IDLE.
  - o_ready = 1.
  - All other outputs = 0.
  - Internal counters = 0.
- A reset mid-frame emits no o_mt_end. The matcher is reset by the same i_rst.

## Test plan
- Normal frame: start, 3 keypoints on consecutive cycles, end; i_mt_valid ×2; i_mt_end 5 cycles later → o_mt_flag high 3 cycles, each one cycle after input; o_key_cnt = 3, o_match_cnt = 2, o_frame_id = 1; o_frame_done pulse; o_timeout = 0.
- Cap with MAX_KEYS = 4: frame with 7 keypoints → 4 forwarded; o_key_cnt = 4, o_drop_cnt = 3.
- Timeout with TIMEOUT = 8: i_mt_end never asserted → DONE exactly 8 cycles after DRAIN entry; o_timeout = 1 until the next start.
- Simultaneous strobes: i_start + i_end in one cycle → o_mt_start and o_mt_end both high the next cycle; o_key_cnt = 0. Separately, i_flag + i_end in one cycle → o_key_cnt includes that keypoint.
- Backpressure and ignore: i_flag during DRAIN → no o_mt_flag, o_drop_cnt unchanged. i_flag in IDLE → ignored.
- Reset mid-RECV after 2 keypoints → next cycle IDLE, o_ready = 1, all counters and o_frame_id = 0. Next frame reports o_frame_id = 1.
